// File: rtl/console_mux_pkg.sv
// console_mux_pkg: shared selector helpers and channel state encoding for the console mux/demux pair
package console_mux_pkg;
    typedef logic [1:0] chan_state_t;
    localparam chan_state_t CONN      = 2'd0;
    localparam chan_state_t WAIT_IDLE = 2'd1;
    localparam chan_state_t GAP       = 2'd2;
    function automatic int unsigned sel_none(input int unsigned sel_w);
        return (32'd1 << sel_w) - 32'd1;
    endfunction
    function automatic logic sel_valid(input int unsigned sel, input int unsigned pins);
        return sel < pins;
    endfunction
    function automatic int unsigned sel_slice(input logic [255:0] bus, input int unsigned k, input int unsigned w);
        return 32'((bus >> (k * w)) & ((256'd1 << w) - 256'd1));
    endfunction
endpackage

// File: rtl/console_route_chan.sv
// console_route_chan: one transmit channel's glitch-free pin switch (idle wait, undriven gap, commit)
module console_route_chan
    import console_mux_pkg::*;
#(
    parameter int PIN_COUNT   = 4,
    parameter int SEL_W       = 4,
    parameter int IDLE_CYCLES = 16,
    parameter int GAP_CYCLES  = 2,
    parameter int MAX_WAIT    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tx,
    input  logic [SEL_W-1:0] req_sel,
    output logic [SEL_W-1:0] active_sel,
    output chan_state_t      state
);
    localparam int IW = IDLE_CYCLES > 0 ? $clog2(IDLE_CYCLES + 1) : 1;
    localparam int WW = MAX_WAIT > 0 ? $clog2(MAX_WAIT + 1) : 1;
    localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
    logic [IW-1:0] idle_cnt, idle_nxt;
    logic [WW-1:0] wait_cnt, wait_nxt;
    logic [GW-1:0] gap_cnt;
    logic          idle_done, wait_done;
    always_comb begin
        idle_nxt  = tx ? (idle_cnt == IW'(IDLE_CYCLES) ? idle_cnt : idle_cnt + 1'b1) : '0;
        wait_nxt  = wait_cnt == WW'(MAX_WAIT) ? wait_cnt : wait_cnt + 1'b1;
        idle_done = idle_nxt == IW'(IDLE_CYCLES);
        wait_done = MAX_WAIT != 0 && wait_nxt == WW'(MAX_WAIT);
    end
    // Leaving NONE goes straight to GAP: there is no old line mid-character to protect.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= CONN;
            active_sel <= SEL_W'(sel_none(SEL_W));
            idle_cnt   <= '0;
            wait_cnt   <= '0;
            gap_cnt    <= '0;
        end else begin
            case (state)
                CONN: if (req_sel != active_sel) begin
                    state    <= sel_valid(32'(active_sel), PIN_COUNT) ? WAIT_IDLE : GAP;
                    idle_cnt <= '0;
                    wait_cnt <= '0;
                    gap_cnt  <= '0;
                end
                WAIT_IDLE: if (req_sel == active_sel) begin
                    state    <= CONN;
                    idle_cnt <= '0;
                    wait_cnt <= '0;
                end else begin
                    idle_cnt <= idle_nxt;
                    wait_cnt <= wait_nxt;
                    if (idle_done || wait_done) begin
                        state   <= GAP;
                        gap_cnt <= '0;
                    end
                end
                GAP: if (int'(gap_cnt) + 1 >= GAP_CYCLES) begin
                    state      <= CONN;
                    active_sel <= req_sel;
                end else
                    gap_cnt <= gap_cnt + 1'b1;
                default: state <= CONN;
            endcase
        end
endmodule

// File: rtl/console_demux.sv
// console_demux: routes host transmit channels onto selected GPIO pins with glitch-free switching
module console_demux
    import console_mux_pkg::*;
#(
    parameter int PIN_COUNT     = 4,
    parameter int CHANNEL_COUNT = 4,
    parameter int SEL_W         = 4,
    parameter int IDLE_CYCLES   = 16,
    parameter int GAP_CYCLES    = 2,
    parameter int MAX_WAIT      = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CHANNEL_COUNT-1:0]   host_tx,
    input  logic [CHANNEL_COUNT*SEL_W-1:0] selectors,
    output logic [PIN_COUNT-1:0]       gpio_out,
    output logic [PIN_COUNT-1:0]       gpio_oe,
    output logic [CHANNEL_COUNT-1:0]   busy,
    output logic [CHANNEL_COUNT-1:0]   conflict
);
    logic [SEL_W-1:0]         req_sel [CHANNEL_COUNT];
    logic [SEL_W-1:0]         act_sel [CHANNEL_COUNT];
    chan_state_t              st      [CHANNEL_COUNT];
    logic [CHANNEL_COUNT-1:0] drv;
    logic [PIN_COUNT-1:0]     out_nxt, oe_nxt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int k = 0; k < CHANNEL_COUNT; k++) req_sel[k] <= SEL_W'(sel_none(SEL_W));
            gpio_out <= '1;
            gpio_oe  <= '0;
        end else begin
            for (int k = 0; k < CHANNEL_COUNT; k++) req_sel[k] <= SEL_W'(sel_slice(256'(selectors), k, SEL_W));
            gpio_out <= out_nxt;
            gpio_oe  <= oe_nxt;
        end
    for (genvar k = 0; k < CHANNEL_COUNT; k++) begin : g_ch
        console_route_chan #(
            .PIN_COUNT(PIN_COUNT), .SEL_W(SEL_W), .IDLE_CYCLES(IDLE_CYCLES),
            .GAP_CYCLES(GAP_CYCLES), .MAX_WAIT(MAX_WAIT)
        ) u_chan (
            .clk(clk), .rst_n(rst_n), .tx(host_tx[k]), .req_sel(req_sel[k]),
            .active_sel(act_sel[k]), .state(st[k])
        );
        assign drv[k]  = st[k] != GAP && sel_valid(32'(act_sel[k]), PIN_COUNT);
        assign busy[k] = st[k] != CONN;
    end
    // Descending scan so the lowest-index channel wins each pin.
    always_comb begin
        out_nxt  = '1;
        oe_nxt   = '0;
        conflict = '0;
        for (int p = 0; p < PIN_COUNT; p++)
            for (int k = CHANNEL_COUNT - 1; k >= 0; k--)
                if (drv[k] && int'(act_sel[k]) == p) begin
                    oe_nxt[p]  = 1'b1;
                    out_nxt[p] = host_tx[k];
                end
        for (int k = 1; k < CHANNEL_COUNT; k++)
            for (int j = 0; j < k; j++)
                if (st[k] == CONN && drv[k] && drv[j] && act_sel[j] == act_sel[k]) conflict[k] = 1'b1;
    end
endmodule
